ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 4K x 16 RAM (clk, load, addr[11:0], d[15:0], q[15:0]) between two
//  requesters: port 0 = instruction fetch, port 1 = load/store unit. Accepts at most one access
//  per cycle, drives the RAM pins from registers, and routes read data back to the requester
//  with an in-order tag pipeline. Sits between the CPU core and the ram instance.
// PARAMETERS
//  RD_LAT     1   RAM read latency in cycles, from addr presented on RAM pins to q valid (1..4)
//  FIXED_PRI  0   0 = round-robin between ports; 1 = port 0 always wins when both request
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  req0/req1   in   1   access request; held with its fields stable until gnt seen
//  we0/we1     in   1   1 = write, 0 = read
//  addr0/addr1 in   12  word address
//  wd0/wd1     in   16  write data (ignored for reads)
//  gnt0/gnt1   out  1   combinational accept pulse; request is consumed in this cycle
//  rv0/rv1     out  1   read data valid, one cycle per accepted read
//  rd0/rd1     out  16  read data; = ram_q when rvN=1, else 16'h0000
//  ram_load    out  1   RAM write enable (registered)
//  ram_addr    out  12  RAM address (registered)
//  ram_d       out  16  RAM write data (registered)
//  ram_q       in   16  RAM read data
//  idle        out  1   1 when no read is in flight and no RAM access is being presented
// BEHAVIOUR
//  - Reset (async, rst=1): ram_load=0, ram_addr=0, ram_d=0, rv0=rv1=0, rd0=rd1=0, gnt0=gnt1=0
//    (forced low while rst=1), rr pointer -> port 0 preferred, tag pipeline cleared, idle=1.
//  - Arbitration (cycle N, combinational): only one req -> that port granted. Both req:
//    FIXED_PRI=1 -> port 0; FIXED_PRI=0 -> port not granted most recently (pointer updates on
//    every grant). Never gnt0 and gnt1 together. No req -> no gnt.
//  - Issue: at edge ending cycle N, ram_addr/ram_d/ram_load <= granted fields (load=we).
//    No grant -> ram_load<=0, ram_addr/ram_d hold. RAM pins valid in cycle N+1; write lands at
//    edge ending N+1. A write's ram_load is high exactly one cycle.
//  - Read return: accepted read in cycle N -> rvX=1 in cycle N+1+RD_LAT only, rdX=ram_q.
//    Tag pipeline depth RD_LAT+1 carries {valid, port}; writes insert no tag.
//  - Throughput: one access/cycle sustained, back-to-back reads fully pipelined; returns
//    strictly in issue order across both ports.
//  - Hazards: write then read same address in consecutive grants -> read returns new data
//    (ordering guaranteed by RAM issue order; no forwarding logic).
//  - Requester may drop req without gnt (no accept, no side effect); pointer unchanged.
//  - idle = ~ram_load & no valid tag in pipeline & no read presented on RAM pins.
//  - Reset mid-operation: in-flight reads discarded, no rv pulses after rst deasserts,
//    pending requests must be re-presented; RAM contents untouched by controller.
//  - Address/data widths exact; no wrap arithmetic; addr 12'hFFF legal.
// TESTING
//  1 Write single: req1=1,we1=1,addr1=0x010,wd1=0x0055 -> gnt1 same cycle; next cycle
//    ram_load=1,ram_addr=0x010,ram_d=0x0055; following cycle ram_load=0.
//  2 Read-after-write: after test 1, req0 read 0x010 -> rv0=1 exactly 2 cycles after gnt0
//    (RD_LAT=1), rd0=0x0055; rv1 stays 0.
//  3 Contention RR: req0,req1 both held reading 0x000/0x001 for 4 cycles -> grants
//    alternate 0,1,0,1; rv pulses return in same order with correct data.
//  4 FIXED_PRI=1, both req held -> gnt0 every cycle, gnt1 never until req0 drops.
//  5 Back-to-back reads 0x000..0x00F on port 0 -> 16 consecutive rv0 pulses, data in order,
//    idle=0 throughout, idle=1 one cycle after last rv0.
//  6 rst pulsed with 2 reads in flight -> all outputs zero immediately, no rv after release,
//    next request granted normally with port 0 preferred.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port 4K x 16 RAM: one access per cycle,
// registered RAM pins, and in-order read-data return steered by a tag pipeline.
module ram_arbiter #(
    parameter int unsigned RD_LAT    = 1,
    parameter bit          FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [15:0] wd0,
    input  logic [15:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rv0,
    output logic        rv1,
    output logic [15:0] rd0,
    output logic [15:0] rd1,
    output logic        ram_load,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_d,
    input  logic [15:0] ram_q,
    output logic        idle
);

    logic              pref1;
    logic              any_gnt;
    logic              sel_we;
    logic [11:0]       sel_addr;
    logic [15:0]       sel_wd;
    logic [RD_LAT:0]   tag_v;
    logic [RD_LAT:0]   tag_p;

    // pref1 names the port that wins a tie in round-robin mode
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && (!req1 || FIXED_PRI || !pref1))
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
    end

    always_comb begin
        any_gnt  = gnt0 | gnt1;
        sel_we   = we0;
        sel_addr = addr0;
        sel_wd   = wd0;
        if (gnt1) begin
            sel_we   = we1;
            sel_addr = addr1;
            sel_wd   = wd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref1    <= 1'b0;
            ram_load <= 1'b0;
            ram_addr <= '0;
            ram_d    <= '0;
            tag_v    <= '0;
            tag_p    <= '0;
        end else begin
            ram_load <= any_gnt & sel_we;
            if (any_gnt) begin
                ram_addr <= sel_addr;
                ram_d    <= sel_wd;
                pref1    <= gnt0;
            end
            // stage 0 lines up with the address on the RAM pins, stage RD_LAT with ram_q
            tag_v <= {tag_v[RD_LAT-1:0], any_gnt & ~sel_we};
            tag_p <= {tag_p[RD_LAT-1:0], gnt1};
        end
    end

    always_comb begin
        rv0  = tag_v[RD_LAT] & ~tag_p[RD_LAT];
        rv1  = tag_v[RD_LAT] &  tag_p[RD_LAT];
        rd0  = rv0 ? ram_q : '0;
        rd1  = rv1 ? ram_q : '0;
        idle = ~ram_load & ~(|tag_v);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances share one stimulus,
// each with its own RAM; a cycle-level model checks every output on each falling edge.
module tb_ram_arbiter;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [11:0] addr0 = '0, addr1 = '0;
    logic [15:0] wd0 = '0, wd1 = '0;

    logic        d_gnt0 [2], d_gnt1 [2], d_rv0 [2], d_rv1 [2], d_load [2], d_idle [2];
    logic [15:0] d_rd0 [2], d_rd1 [2], d_d [2], d_q [2];
    logic [11:0] d_addr [2];

    logic [15:0] ram   [2][4096];
    bit          ram_wr[2][4096];
    logic [15:0] qpipe [2][RD_LAT];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.RD_LAT(RD_LAT), .FIXED_PRI(1'b0)) u_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(d_gnt0[0]), .gnt1(d_gnt1[0]), .rv0(d_rv0[0]), .rv1(d_rv1[0]),
        .rd0(d_rd0[0]), .rd1(d_rd1[0]), .ram_load(d_load[0]), .ram_addr(d_addr[0]),
        .ram_d(d_d[0]), .ram_q(d_q[0]), .idle(d_idle[0])
    );

    ram_arbiter #(.RD_LAT(RD_LAT), .FIXED_PRI(1'b1)) u_fix (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
        .gnt0(d_gnt0[1]), .gnt1(d_gnt1[1]), .rv0(d_rv0[1]), .rv1(d_rv1[1]),
        .rd0(d_rd0[1]), .rd1(d_rd1[1]), .ram_load(d_load[1]), .ram_addr(d_addr[1]),
        .ram_d(d_d[1]), .ram_q(d_q[1]), .idle(d_idle[1])
    );

    // Never-written RAM words read back as 0xA000 | address.
    function automatic logic [15:0] seed(input logic [11:0] a);
        return {4'hA, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // RAM environment: write on the edge after ram_load, read data RD_LAT cycles after address.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (d_load[k] === 1'b1) begin
                ram[k][d_addr[k]]    <= d_d[k];
                ram_wr[k][d_addr[k]] <= 1'b1;
            end
            qpipe[k][0] <= ram_wr[k][d_addr[k]] ? ram[k][d_addr[k]] : seed(d_addr[k]);
            for (int j = 1; j < RD_LAT; j++)
                qpipe[k][j] <= qpipe[k][j-1];
        end
    end
    assign d_q[0] = qpipe[0][RD_LAT-1];
    assign d_q[1] = qpipe[1][RD_LAT-1];

    // ---------------- model and per-cycle compare ----------------
    int unsigned cyc = 0;
    bit          m_last [2];
    logic        m_load [2];
    logic [11:0] m_addr [2];
    logic [15:0] m_d    [2];
    bit          m_prev [2];
    int          m_pend [2];
    logic [15:0] m_mem  [2][4096];
    bit          m_wr   [2][4096];
    bit          ret_v  [2][16];
    bit          ret_p  [2][16];
    logic [15:0] ret_d  [2][16];

    always @(negedge clk) begin : cmp
        bit          eg0, eg1, win1, ev0, ev1, eidle, port, wr;
        logic [15:0] er0, er1, w;
        logic [11:0] a;
        logic [3:0]  s, ds;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_last[k] = 1'b1;
                m_load[k] = 1'b0;
                m_addr[k] = '0;
                m_d[k]    = '0;
                m_prev[k] = 1'b0;
                m_pend[k] = 0;
                for (int i = 0; i < 16; i++) ret_v[k][i] = 1'b0;
            end
            s     = cyc[3:0];
            ev0   = ret_v[k][s] && !ret_p[k][s];
            ev1   = ret_v[k][s] &&  ret_p[k][s];
            er0   = ev0 ? ret_d[k][s] : 16'h0000;
            er1   = ev1 ? ret_d[k][s] : 16'h0000;
            eidle = !m_prev[k] && (m_pend[k] == 0);
            eg0   = 1'b0;
            eg1   = 1'b0;
            if (!rst && (req0 || req1)) begin
                if (req0 && req1) win1 = (k == 1) ? 1'b0 : !m_last[k];
                else              win1 = req1;
                eg0 = !win1;
                eg1 = win1;
            end
            chk($sformatf("u%0d.gnt0", k), d_gnt0[k], eg0);
            chk($sformatf("u%0d.gnt1", k), d_gnt1[k], eg1);
            chk($sformatf("u%0d.ram_load", k), d_load[k], m_load[k]);
            chk($sformatf("u%0d.ram_addr", k), d_addr[k], m_addr[k]);
            chk($sformatf("u%0d.ram_d", k), d_d[k], m_d[k]);
            chk($sformatf("u%0d.rv0", k), d_rv0[k], ev0);
            chk($sformatf("u%0d.rv1", k), d_rv1[k], ev1);
            chk($sformatf("u%0d.rd0", k), d_rd0[k], er0);
            chk($sformatf("u%0d.rd1", k), d_rd1[k], er1);
            chk($sformatf("u%0d.idle", k), d_idle[k], eidle);
            if (!rst) begin
                if (ret_v[k][s]) begin
                    ret_v[k][s] = 1'b0;
                    m_pend[k]--;
                end
                m_load[k] = 1'b0;
                if (eg0 || eg1) begin
                    port = eg1;
                    wr   = port ? we1 : we0;
                    a    = port ? addr1 : addr0;
                    w    = port ? wd1 : wd0;
                    m_load[k] = wr;
                    m_addr[k] = a;
                    m_d[k]    = w;
                    m_last[k] = port;
                    if (wr) begin
                        m_mem[k][a] = w;
                        m_wr[k][a]  = 1'b1;
                    end else begin
                        ds = 4'(cyc + 1 + RD_LAT);
                        ret_v[k][ds] = 1'b1;
                        ret_p[k][ds] = port;
                        ret_d[k][ds] = m_wr[k][a] ? m_mem[k][a] : seed(a);
                        m_pend[k]++;
                    end
                end
                m_prev[k] = eg0 || eg1;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_seq;
        rr_seq = 4'b0101;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("reset ram_load", d_load[0], 0);
        chk("reset ram_addr", d_addr[0], 0);
        chk("reset idle", d_idle[0], 1);
        req0 = 1'b1;
        #1;
        chk("reset gnt0 forced low", d_gnt0[0], 0);
        req0 = 1'b0;
        tick;
        tick;
        rst = 1'b0;

        // single write on port 1, then read it back on port 0
        tick;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h010; wd1 = 16'h0055;
        #1;
        chk("t1 gnt1", d_gnt1[0], 1);
        chk("t1 gnt0", d_gnt0[0], 0);
        tick;
        req1 = 1'b0; we1 = 1'b0;
        #1;
        chk("t1 ram_load", d_load[0], 1);
        chk("t1 ram_addr", d_addr[0], 12'h010);
        chk("t1 ram_d", d_d[0], 16'h0055);
        tick;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        #1;
        chk("t1 ram_load drop", d_load[0], 0);
        chk("t2 gnt0", d_gnt0[0], 1);
        tick;
        req0 = 1'b0;
        #1;
        chk("t2 rv0 early", d_rv0[0], 0);
        tick;
        chk("t2 rv0", d_rv0[0], 1);
        chk("t2 rd0", d_rd0[0], 16'h0055);
        chk("t2 rv1", d_rv1[0], 0);

        // contention: round-robin alternates, fixed priority keeps port 0
        tick;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3 rr gnt1 #%0d", i), d_gnt1[0], rr_seq[i]);
            chk($sformatf("t4 fix gnt0 #%0d", i), d_gnt0[1], 1);
            chk($sformatf("t4 fix gnt1 #%0d", i), d_gnt1[1], 0);
            if (i == 2) chk("t3 rr rd1 first", d_rd1[0], 16'hA001);
            if (i == 3) chk("t3 rr rd0 second", d_rd0[0], 16'hA000);
            tick;
        end
        req0 = 1'b0;
        #1;
        chk("t4 fix gnt1 after drop", d_gnt1[1], 1);
        tick;
        req1 = 1'b0;
        repeat (4) tick;

        // 16 back-to-back reads on port 0
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 12'(c);
            end else begin
                req0 = 1'b0;
            end
            #1;
            if (c < 16) chk($sformatf("t5 gnt0 #%0d", c), d_gnt0[0], 1);
            if (c >= 2 && c <= 17) begin
                chk($sformatf("t5 rv0 #%0d", c), d_rv0[0], 1);
                chk($sformatf("t5 rd0 #%0d", c), d_rd0[0], 32'hA000 + 32'(c - 2));
            end
            if (c >= 1 && c <= 17) chk($sformatf("t5 idle busy #%0d", c), d_idle[0], 0);
            if (c == 18) chk("t5 idle after last", d_idle[0], 1);
            tick;
        end

        // top address: write 0xFFF then read it back immediately
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'hFFF; wd1 = 16'hBEEF;
        #1;
        chk("t7 gnt1", d_gnt1[0], 1);
        tick;
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'hFFF;
        #1;
        chk("t7 gnt0", d_gnt0[0], 1);
        chk("t7 ram_addr", d_addr[0], 12'hFFF);
        tick;
        req0 = 1'b0;
        tick;
        chk("t7 rv0", d_rv0[0], 1);
        chk("t7 rd0", d_rd0[0], 16'hBEEF);
        repeat (3) tick;

        // reset with two reads in flight
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
        tick;
        addr0 = 12'h021;
        tick;
        req0 = 1'b0;
        rst = 1'b1;
        req1 = 1'b1;
        #1;
        chk("t6 rv0 killed", d_rv0[0], 0);
        chk("t6 rd0 zero", d_rd0[0], 0);
        chk("t6 ram_addr zero", d_addr[0], 0);
        chk("t6 idle", d_idle[0], 1);
        chk("t6 gnt1 forced low", d_gnt1[0], 0);
        tick;
        tick;
        rst = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t6 no rv0 #%0d", i), d_rv0[0], 0);
            tick;
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h030;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h031;
        #1;
        chk("t6 port0 preferred", d_gnt0[0], 1);
        chk("t6 port1 waits", d_gnt1[0], 0);
        tick;
        req0 = 1'b0;
        tick;
        req1 = 1'b0;
        repeat (5) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
